usb_cmd_deframer: RTL
=====================

# usb_cmd_deframer

Receive-side packet deframer that sits directly downstream of the EZ-USB slave-FIFO interface. It consumes the 16-bit EZ-USB -> FPGA word stream through its DO/DO_valid/DO_ready handshake. It hunts for packet headers, emits a header record, and streams the payload with a last marker. It then verifies a trailing 16-bit additive checksum and reports the packet result. Framing and checksum errors are counted in saturating counters for host readback.

## Interface
Parameters:
- SYNC, 8'hA5, required value of header word bits [15:8]
- MAX_LEN, 12'd2048, largest legal payload length in words; larger lengths are framing errors

Ports:
- ifclk  in  1  interface clock, same clock as the EZ-USB interface
- reset  in  1  asynchronous, active-high reset
- in_data  in  16  word from EZ-USB interface (DO)
- in_valid  in  1  in_data valid (DO_valid)
- in_ready  out  1  word accepted on edge where in_valid && in_ready (drives DO_ready)
- hdr_valid  out  1  header record valid
- hdr_ready  in  1  header consumer accepts
- hdr_cmd  out  8  command byte
- hdr_dest  out  4  destination id
- hdr_len  out  12  payload length in words
- pl_data  out  16  payload word
- pl_valid  out  1  payload word valid
- pl_ready  in  1  payload consumer accepts
- pl_last  out  1  final payload word of the packet
- end_valid  out  1  one-cycle pulse: packet complete
- end_ok  out  1  checksum matched; qualified by end_valid
- sync_err_cnt  out  16  saturating count of framing errors
- cksum_err_cnt  out  16  saturating count of checksum mismatches
- state  out  3  debug, current FSM state

## Operation
- Packet format: W0 = {SYNC, cmd}; W1 = {dest[3:0], len[11:0]}; then len payload words; then checksum word = 16-bit sum, modulo 2^16, of W0, W1 and all payload words.
- Running sum register (16 bit, wraps) is loaded with W0 and accumulates every later accepted word except the checksum word.
- FSM states:
  - HUNT: in_ready=1. Word with [15:8]==SYNC latches cmd, sum<=word, goes to LEN. Any other word increments sync_err_cnt and stays in HUNT.
  - LEN: in_ready=1. If len>MAX_LEN: increment sync_err_cnt, go to HUNT, no header emitted. Otherwise latch dest/len, sum+=word, set remaining<=len, set hdr_valid<=1, go to HDR.
  - HDR: in_ready=0. On hdr_valid&&hdr_ready clear hdr_valid and go to PAYLOAD if len!=0, else CKSUM.
  - PAYLOAD: in_ready = !pl_valid || pl_ready. On acceptance: pl_data<=word, pl_valid<=1, pl_last<=(remaining==1), sum+=word, remaining-=1. Acceptance with remaining==1 goes to CKSUM.
  - CKSUM: in_ready = !pl_valid, so the last payload word drains first. On acceptance: end_valid<=1, end_ok<=(word==sum). On mismatch increment cksum_err_cnt. Go to HUNT.
- pl_valid clears on the pl_ready handshake unless a new word is loaded in the same cycle.
- Payload is forwarded before verification. Consumers discard on end_ok=0.
- Counters saturate at 16'hFFFF and never wrap.
- hdr_cmd/hdr_dest/hdr_len hold their values from LEN acceptance until the next LEN acceptance.

## Timing
- Reset values: in_ready=0 while reset is asserted and 1 in the first cycle after release (HUNT). All other outputs are 0 and the state is HUNT.
- Reset asserted mid-packet aborts immediately. No end_valid is produced, and the counters clear.
- in_ready is combinational from state, pl_valid and pl_ready only. It never depends on in_valid.
- hdr_valid rises the cycle after the W1 acceptance edge.
- Payload latency: a word accepted at edge k appears on pl_data/pl_valid in the cycle after edge k.
- With pl_ready held at 1, payload throughput is 1 word per clock.
- end_valid is high for exactly the one cycle after the checksum acceptance edge. It is not backpressured.
- Minimum packet (len=0) occupies 4 clock cycles given hdr_ready=1, with HDR held for 1 cycle.
- Back-to-back packets: HUNT accepts the next W0 on the clock following the checksum acceptance.

## Test plan
- Good packet: A507, 3003, 1111, 2222, 3333, 3B70 -> header cmd=07, dest=3, len=3. Payload 1111/2222/3333 with pl_last only on 3333. end_valid pulse with end_ok=1. Both counters 0.
- Same packet with checksum 3B71 -> payload delivered, end_ok=0, cksum_err_cnt=1.
- Words 1234, 00A5, then the good packet -> sync_err_cnt=2, then the packet is parsed with end_ok=1.
- Zero length: A501, 5000, F501 -> hdr_len=0, dest=5. pl_valid never asserts. end_ok=1.
- Backpressure: hold hdr_ready=0 for 10 cycles, then toggle pl_ready every cycle on the good packet -> in_ready=0 throughout HDR. No payload word lost or duplicated. end_ok=1.
- Illegal length: A502, 0801 -> sync_err_cnt+1, return to HUNT, no hdr_valid. Separately, assert reset after the 2nd payload word -> all outputs 0 immediately, no end_valid, next packet parses cleanly.

Source files
------------

// File: rtl/usb_cmd_deframer.sv
// Receive-side deframer for the EZ-USB word stream: header hunt, payload
// forwarding, trailing additive checksum check and error counters.
module usb_cmd_deframer #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [11:0] MAX_LEN = 12'd2048
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [7:0]  hdr_cmd,
  output logic [3:0]  hdr_dest,
  output logic [11:0] hdr_len,
  output logic [15:0] pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        pl_last,
  output logic        end_valid,
  output logic        end_ok,
  output logic [15:0] sync_err_cnt,
  output logic [15:0] cksum_err_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    CKSUM   = 3'd4
  } state_t;

  state_t      st_q, st_d;
  logic [15:0] sum_q, sum_d;
  logic [11:0] rem_q, rem_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  hcmd_q, hcmd_d;
  logic [3:0]  dest_q, dest_d;
  logic [11:0] len_q, len_d;
  logic        hv_q, hv_d;
  logic [15:0] pd_q, pd_d;
  logic        pv_q, pv_d;
  logic        pl_q, pl_d;
  logic        ev_q, ev_d;
  logic        eo_q, eo_d;
  logic [15:0] se_q, se_d;
  logic [15:0] ce_q, ce_d;
  logic        rdy;
  logic        acc;

  always_comb begin
    rdy = 1'b0;
    unique case (st_q)
      HUNT:    rdy = 1'b1;
      LEN:     rdy = 1'b1;
      HDR:     rdy = 1'b0;
      PAYLOAD: rdy = !pv_q || pl_ready;
      CKSUM:   rdy = !pv_q;
      default: rdy = 1'b0;
    endcase
  end

  assign in_ready = rdy && !reset;
  assign acc      = in_valid && in_ready;

  always_comb begin
    st_d   = st_q;
    sum_d  = sum_q;
    rem_d  = rem_q;
    cmd_d  = cmd_q;
    hcmd_d = hcmd_q;
    dest_d = dest_q;
    len_d  = len_q;
    hv_d   = hv_q;
    pd_d   = pd_q;
    pv_d   = pv_q;
    pl_d   = pl_q;
    ev_d   = 1'b0;
    eo_d   = eo_q;
    se_d   = se_q;
    ce_d   = ce_q;
    // a word loaded this cycle overrides the handshake clear below
    if (pv_q && pl_ready) begin
      pv_d = 1'b0;
      pl_d = 1'b0;
    end
    unique case (st_q)
      HUNT: if (acc) begin
        if (in_data[15:8] == SYNC) begin
          cmd_d = in_data[7:0];
          sum_d = in_data;
          st_d  = LEN;
        end else if (se_q != 16'hFFFF) begin
          se_d = se_q + 16'd1;
        end
      end
      LEN: if (acc) begin
        if (in_data[11:0] > MAX_LEN) begin
          if (se_q != 16'hFFFF) se_d = se_q + 16'd1;
          st_d = HUNT;
        end else begin
          hcmd_d = cmd_q;
          dest_d = in_data[15:12];
          len_d  = in_data[11:0];
          rem_d  = in_data[11:0];
          sum_d  = sum_q + in_data;
          hv_d   = 1'b1;
          st_d   = HDR;
        end
      end
      HDR: if (hv_q && hdr_ready) begin
        hv_d = 1'b0;
        st_d = (len_q != 12'd0) ? PAYLOAD : CKSUM;
      end
      PAYLOAD: if (acc) begin
        pd_d  = in_data;
        pv_d  = 1'b1;
        pl_d  = (rem_q == 12'd1);
        sum_d = sum_q + in_data;
        rem_d = rem_q - 12'd1;
        if (rem_q == 12'd1) st_d = CKSUM;
      end
      CKSUM: if (acc) begin
        ev_d = 1'b1;
        eo_d = (in_data == sum_q);
        if (in_data != sum_q && ce_q != 16'hFFFF)
          ce_d = ce_q + 16'd1;
        st_d = HUNT;
      end
      default: st_d = HUNT;
    endcase
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      st_q   <= HUNT;
      sum_q  <= '0;
      rem_q  <= '0;
      cmd_q  <= '0;
      hcmd_q <= '0;
      dest_q <= '0;
      len_q  <= '0;
      hv_q   <= 1'b0;
      pd_q   <= '0;
      pv_q   <= 1'b0;
      pl_q   <= 1'b0;
      ev_q   <= 1'b0;
      eo_q   <= 1'b0;
      se_q   <= '0;
      ce_q   <= '0;
    end else begin
      st_q   <= st_d;
      sum_q  <= sum_d;
      rem_q  <= rem_d;
      cmd_q  <= cmd_d;
      hcmd_q <= hcmd_d;
      dest_q <= dest_d;
      len_q  <= len_d;
      hv_q   <= hv_d;
      pd_q   <= pd_d;
      pv_q   <= pv_d;
      pl_q   <= pl_d;
      ev_q   <= ev_d;
      eo_q   <= eo_d;
      se_q   <= se_d;
      ce_q   <= ce_d;
    end
  end

  assign hdr_valid     = hv_q;
  assign hdr_cmd       = hcmd_q;
  assign hdr_dest      = dest_q;
  assign hdr_len       = len_q;
  assign pl_data       = pd_q;
  assign pl_valid      = pv_q;
  assign pl_last       = pl_q;
  assign end_valid     = ev_q;
  assign end_ok        = eo_q;
  assign sync_err_cnt  = se_q;
  assign cksum_err_cnt = ce_q;
  assign state         = st_q;

endmodule
